// File: rtl/pipe_skid.sv
// Valid/ready register slice with a one-entry skid buffer; in_rdy and out_vld are both flopped.
// Optional saturating stall counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             flush,
    input  logic             in_vld,
    input  logic [W-1:0]     in_data,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [W-1:0]     out_data,
    input  logic             out_rdy
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StBusy  = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         out_vld_q, out_vld_d;
    logic         in_rdy_q, in_rdy_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         accept;

    assign accept = in_vld & in_rdy_q;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        skid_data_d = skid_data_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d    = StBusy;
                    out_data_d = in_data;
                end
            end
            StBusy: begin
                if (accept && out_rdy) begin
                    out_data_d = in_data;
                end else if (accept) begin
                    state_d     = StFull;
                    skid_data_d = in_data;
                end else if (out_rdy) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_rdy) begin
                    state_d    = StBusy;
                    out_data_d = skid_data_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush discards everything, including a beat accepted this cycle.
        if (flush) begin
            state_d = StEmpty;
        end
        out_vld_d = (state_d != StEmpty);
        in_rdy_d  = (state_d != StFull);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= StEmpty;
            out_vld_q   <= 1'b0;
            in_rdy_q    <= 1'b1;
            out_data_q  <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            out_vld_q   <= out_vld_d;
            in_rdy_q    <= in_rdy_d;
            out_data_q  <= out_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_rdy   = in_rdy_q;
    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (out_vld_q && !out_rdy && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// Scoreboard bench for pipe_skid: a queue of held beats predicts out_vld, in_rdy and out_data.
module tb_pipe_skid;

    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 4;

    logic         clk = 1'b0;
    logic         arst_n;
    logic         flush;
    logic         in_vld;
    logic [W-1:0] in_data;
    logic         in_rdy;
    logic         out_vld;
    logic [W-1:0] out_data;
    logic         out_rdy;
`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] model_q[$];
    int           stall_m = 0;

    pipe_skid #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy)
`ifdef PIPE_SKID_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the queue, then advance it for the coming edge.
    initial begin
        bit acc;
        bit del;
        bit exp_vld;
        bit exp_rdy;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                model_q.delete();
                stall_m = 0;
                chk("rst_out_vld", out_vld, 0);
                chk("rst_in_rdy", in_rdy, 1);
                chk("rst_out_data", out_data, 0);
            end else begin
                exp_vld = model_q.size() > 0;
                exp_rdy = model_q.size() < 2;
                chk("out_vld", out_vld, exp_vld);
                chk("in_rdy", in_rdy, exp_rdy);
                if (exp_vld) chk("out_data", out_data, model_q[0]);
`ifdef PIPE_SKID_STALL_CNT_EN
                chk("stall_cnt", stall_cnt, stall_m);
`endif
                acc = in_vld && exp_rdy;
                del = exp_vld && out_rdy;
                if (del) void'(model_q.pop_front());
                if (flush) model_q.delete();
                else if (acc) model_q.push_back(in_data);
                if (flush) stall_m = 0;
                else if (exp_vld && !out_rdy && stall_m < (2 ** CNT_W) - 1) stall_m++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        bit got;
        int budget;
        budget = 0;
        in_vld  = 1'b1;
        in_data = d;
        forever begin
            @(negedge clk);
            got = in_rdy;
            @(posedge clk);
            #1;
            if (got) break;
            budget++;
            if (budget > 50) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        in_vld = 1'b0;
    endtask

    initial begin
        arst_n  = 1'b0;
        flush   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst_n = 1'b1;
        cyc();

        // Streaming at full rate.
        out_rdy = 1'b1;
        for (int i = 0; i < 8; i++) send(i);
        repeat (3) cyc();

        // Backpressure: A held, B skidded, C waits for release.
        send(32'h0A);
        out_rdy = 1'b0;
        send(32'h0B);
        in_vld  = 1'b1;
        in_data = 32'h0C;
        repeat (3) cyc();
        chk("bp_in_rdy_low", in_rdy, 0);
        chk("bp_head_held", out_data, 32'h0A);
        out_rdy = 1'b1;
        send(32'h0C);
        repeat (4) cyc();

        // Bubbles.
        for (int i = 0; i < 8; i++) begin
            send(32'h100 + i);
            cyc();
        end

        // Flush while full, with a new beat offered.
        out_rdy = 1'b0;
        send(32'h11);
        send(32'h22);
        chk("fl_full", in_rdy, 0);
        flush   = 1'b1;
        in_vld  = 1'b1;
        in_data = 32'h33;
        cyc();
        flush  = 1'b0;
        in_vld = 1'b0;
        chk("fl_out_vld", out_vld, 0);
        chk("fl_in_rdy", in_rdy, 1);
        out_rdy = 1'b1;
        repeat (3) cyc();

        // Asynchronous reset between edges while full.
        out_rdy = 1'b0;
        send(32'h44);
        send(32'h45);
        #2 arst_n = 1'b0;
        #1;
        chk("ar_out_vld", out_vld, 0);
        chk("ar_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1 arst_n = 1'b1;
        out_rdy = 1'b1;
        send(32'h55);
        chk("ar_latency_vld", out_vld, 1);
        chk("ar_latency_data", out_data, 32'h55);
        repeat (2) cyc();

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            in_vld  = $urandom_range(0, 1) == 1;
            in_data = $urandom;
            out_rdy = $urandom_range(0, 3) != 0;
            flush   = $urandom_range(0, 31) == 0;
            cyc();
        end
        flush  = 1'b0;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        repeat (3) cyc();

`ifdef PIPE_SKID_STALL_CNT_EN
        flush = 1'b1;
        cyc();
        flush   = 1'b0;
        out_rdy = 1'b0;
        send(32'hAA);
        repeat (20) cyc();
        chk("stall_sat", stall_cnt, 15);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("stall_flush", stall_cnt, 0);
        out_rdy = 1'b1;
        repeat (2) cyc();
`endif

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_skid.md
Name: pipe_skid

Overview:
Full-throughput valid/ready register slice with a one-entry skid buffer. It sits directly upstream of plain dff pipeline stages and decouples their ready path: it registers both the forward path (out_vld/out_data) and the backward path (in_rdy). This breaks long ready chains between producers and dff-based datapaths without losing a cycle of bandwidth.

Parameters:
W, 32, payload width in bits
CNT_W, 16, stall counter width (used only with PIPE_SKID_STALL_CNT_EN)

Ports:
clk  input  1  clock, all state updates on posedge
arst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of all held beats
in_vld  input  1  upstream beat valid
in_data  input  W  upstream payload
in_rdy  output  1  registered; slice can accept a beat this cycle
out_vld  output  1  registered; out_data holds a valid beat
out_data  output  W  registered payload to downstream
out_rdy  input  1  downstream accepts out_data this cycle
stall_cnt  output  CNT_W  saturating stall count (present only with PIPE_SKID_STALL_CNT_EN)

Behaviour:
- Reset: one clock; reset asynchronous, active-low (arst_n). While arst_n=0: state EMPTY, out_vld=0, in_rdy=1, out_data=0, skid data=0, stall_cnt=0.
- Handshakes: accept = in_vld & in_rdy; deliver = out_vld & out_rdy. in_data is ignored unless accept.
- Storage: output register (out_vld/out_data) and skid register (skid_vld/skid_data). in_rdy = ~skid_vld, registered; never combinationally dependent on out_rdy.
- State machine: EMPTY (no beats), BUSY (output register only), FULL (output and skid registers).
  EMPTY: accept -> BUSY, out_data <= in_data.
  BUSY: accept & out_rdy -> BUSY, out_data <= in_data. accept & ~out_rdy -> FULL, skid_data <= in_data. ~accept & out_rdy -> EMPTY. Otherwise hold.
  FULL: in_rdy=0. out_rdy -> BUSY, out_data <= skid_data. Otherwise hold.
- Latency: 1 cycle from accept in EMPTY to out_vld=1. Sustained throughput: 1 beat/cycle.
- Ordering: strict FIFO; no beat dropped or duplicated except by flush.
- Stability: while out_vld & ~out_rdy, out_data and out_vld do not change.
- flush (sync, highest priority): next state EMPTY, out_vld=0, in_rdy=1. A beat accepted in the flush cycle is discarded. Data registers may keep stale values.
- Reset mid-operation: all held beats lost immediately. in_rdy=1 during and after reset.

Optional Feature:
PIPE_SKID_STALL_CNT_EN
- Defined:
  - stall_cnt port exists.
  - stall_cnt increments each cycle with out_vld & ~out_rdy.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared by reset and by flush; flush takes priority over increment in the same cycle.
  - Registered output.
- Undefined: stall_cnt port and counter logic are absent. Core behaviour is identical.

Test Plan:
- Streaming: reset, out_rdy=1, in_vld=1 for 8 cycles with data 0..7 -> out_vld rises 1 cycle after first accept; out_data 0..7 on consecutive cycles; in_rdy stays 1.
- Backpressure: stream A,B,C with out_rdy=0 from the cycle A appears -> A held on out_data, B captured in skid, in_rdy=0 next cycle, C held off. Release out_rdy -> A, B, C delivered in order with no gaps.
- Bubble: alternate in_vld 1/0 with out_rdy=1 -> states EMPTY/BUSY alternate; out_vld toggles, each beat delivered exactly once.
- Flush in FULL: hold 2 beats (0x11, 0x22), assert flush 1 cycle with in_vld=1, data 0x33 -> next cycle out_vld=0, in_rdy=1; no 0x11/0x22/0x33 ever delivered.
- Async reset mid-stream: drop arst_n between clock edges while FULL -> out_vld=0 and in_rdy=1 immediately. After release, next beat 0x55 appears 1 cycle after accept.
- Stall counter (macro on, CNT_W=4): hold out_vld with out_rdy=0 for 20 cycles -> stall_cnt reaches 15 and holds. Flush -> 0.
